// File: rtl/ma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ma_pkg
//  Description : Shared definitions for the memory-access stage: access-size
//                encodings, bit positions inside the combined MA/WB control
//                bus, FSM state type and the load lane-extract/extend helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ma_pkg;

    // Access-size encodings (control bits size[1:0]); 2'b11 is folded to word
    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    // Bit positions inside i_control_ma_wb = {rd, wr, size[1:0], unsigned, reg_write, mem_to_reg}
    localparam int c_ctl_rd         = 6;
    localparam int c_ctl_wr         = 5;
    localparam int c_ctl_size_lsb   = 3;
    localparam int c_ctl_unsigned   = 2;
    localparam int c_ctl_reg_write  = 1;
    localparam int c_ctl_mem_to_reg = 0;

    // Widest supported data word; the extend helper works at this width and
    // callers keep the low NB_DATA bits.
    localparam int c_max_data = 64;

    // Width of the wait-state counter (WAIT_STATES is 0..15)
    localparam int c_nb_wait = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ma_state_t;

    // Pull the addressed lane(s) out of a little-endian word and extend it.
    // Word loads are always lane 0 (aligned), so they pass through unshifted.
    function automatic logic [c_max_data-1:0] lane_extend(
        input logic [c_max_data-1:0] i_word,
        input logic [1:0]            i_lane,
        input logic [1:0]            i_size,
        input logic                  i_unsigned
    );
        logic [c_max_data-1:0] w_shifted;
        logic                  w_sign;
        w_shifted = i_word >> {i_lane, 3'b000};
        w_sign    = 1'b0;
        case (i_size)
            c_size_byte: begin
                w_sign      = w_shifted[7] & ~i_unsigned;
                lane_extend = {{(c_max_data-8){w_sign}}, w_shifted[7:0]};
            end
            c_size_half: begin
                w_sign      = w_shifted[15] & ~i_unsigned;
                lane_extend = {{(c_max_data-16){w_sign}}, w_shifted[15:0]};
            end
            default: begin
                lane_extend = w_shifted;
            end
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_be.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_be
//  Description : N_WORDS x NB_DATA data memory with per-byte write enables,
//                one synchronous write port and two asynchronous read ports
//                (access port and debug port). Contents are not reset.
//  Ports       : i_clk                         write clock
//                i_we / i_be / i_waddr / i_wdata  write strobe, byte lanes,
//                                              word address, data
//                i_raddr -> o_rdata            access read port
//                i_dbg_addr -> o_dbg_data      debug read port
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_be #(
    parameter int NB_DATA  = 32,
    parameter int N_WORDS  = 64,
    parameter int NB_WADDR = $clog2(N_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [NB_DATA/8-1:0]  i_be,
    input  logic [NB_WADDR-1:0]   i_waddr,
    input  logic [NB_DATA-1:0]    i_wdata,
    input  logic [NB_WADDR-1:0]   i_raddr,
    output logic [NB_DATA-1:0]    o_rdata,
    input  logic [NB_WADDR-1:0]   i_dbg_addr,
    output logic [NB_DATA-1:0]    o_dbg_data
);

    localparam int c_nb_lanes = NB_DATA / 8;

    logic [NB_DATA-1:0] r_mem [N_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int lane = 0; lane < c_nb_lanes; lane++) begin
                if (i_be[lane]) begin
                    r_mem[i_waddr][lane*8 +: 8] <= i_wdata[lane*8 +: 8];
                end
            end
        end
    end

    assign o_rdata    = r_mem[i_raddr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/memory_access_ws.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_ws
//  Description : MIPS memory-access stage with byte/half/word loads and
//                stores, sign/zero extension, a WAIT_STATES-cycle data memory
//                with pipeline stall, misalignment suppression with a sticky
//                fault flag, and a debug read port.
//  Ports       : i_clk, i_reset (async, active low)
//                i_control_ma_wb {rd, wr, size[1:0], unsigned, reg_write, mem_to_reg}
//                i_mem_addr / i_mem_data / i_rd_num   access from EX
//                i_dbg_addr -> o_dbg_data             debug word read
//                o_control_wb / o_mem_r_data / o_reg_data / o_reg_num
//                                                     registered to WB
//                o_ex_rd_num / o_ex_ctl_reg_write     forwarding copies
//                o_stall                              hold IF/ID/EX
//                o_misaligned                         sticky fault flag
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_access_ws
    import ma_pkg::*;
#(
    parameter int NB_DATA           = 32,
    parameter int NB_ADDRESS        = 32,
    parameter int N_WORDS           = 64,
    parameter int NB_ADDR_REGISTERS = 5,
    parameter int NB_CONTROL_MA     = 5,
    parameter int NB_CONTROL_WB     = 2,
    parameter int WAIT_STATES       = 2
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic [NB_CONTROL_MA+NB_CONTROL_WB-1:0] i_control_ma_wb,
    input  logic [NB_ADDRESS-1:0]                  i_mem_addr,
    input  logic [NB_DATA-1:0]                     i_mem_data,
    input  logic [NB_ADDR_REGISTERS-1:0]           i_rd_num,
    input  logic [$clog2(N_WORDS)-1:0]             i_dbg_addr,
    output logic [NB_CONTROL_WB-1:0]               o_control_wb,
    output logic [NB_DATA-1:0]                     o_mem_r_data,
    output logic [NB_DATA-1:0]                     o_reg_data,
    output logic [NB_ADDR_REGISTERS-1:0]           o_reg_num,
    output logic [NB_ADDR_REGISTERS-1:0]           o_ex_rd_num,
    output logic                                   o_ex_ctl_reg_write,
    output logic                                   o_stall,
    output logic                                   o_misaligned,
    output logic [NB_DATA-1:0]                     o_dbg_data
);

    localparam int c_nb_waddr = $clog2(N_WORDS);
    localparam int c_nb_lanes = NB_DATA / 8;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_access;
    logic                  w_is_unsigned;
    logic [1:0]            w_size_raw;
    logic [1:0]            w_size;
    logic [1:0]            w_lane;
    logic                  w_misaligned;
    logic [c_nb_waddr-1:0] w_word_idx;

    assign w_rd          = i_control_ma_wb[c_ctl_rd];
    assign w_wr          = i_control_ma_wb[c_ctl_wr];
    assign w_access      = w_rd | w_wr;
    assign w_is_unsigned = i_control_ma_wb[c_ctl_unsigned];
    assign w_size_raw    = i_control_ma_wb[c_ctl_size_lsb +: 2];
    assign w_size        = w_size_raw[1] ? c_size_word : w_size_raw;
    assign w_lane        = i_mem_addr[1:0];
    // Upper address bits are dropped so accesses wrap modulo the depth
    assign w_word_idx    = i_mem_addr[2 +: c_nb_waddr];

    assign w_misaligned = w_access &&
                          (((w_size == c_size_half) && i_mem_addr[0]) ||
                           ((w_size == c_size_word) && (i_mem_addr[1:0] != 2'b00)));

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    ma_state_t            r_state;
    ma_state_t            w_state_next;
    logic [c_nb_wait-1:0] r_wait_cnt;
    logic [c_nb_wait-1:0] w_wait_cnt_next;
    logic                 w_stall;
    logic                 w_commit;   // current cycle is the last one of the op

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_stall         = 1'b0;
        w_commit        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Misaligned and non-memory ops never enter the wait sequence
                if ((WAIT_STATES > 0) && w_access && !w_misaligned) begin
                    w_stall         = 1'b1;
                    w_state_next    = ST_BUSY;
                    w_wait_cnt_next = c_nb_wait'(WAIT_STATES);
                end else begin
                    w_commit = 1'b1;
                end
            end
            ST_BUSY: begin
                if (r_wait_cnt <= c_nb_wait'(1)) begin
                    w_commit        = 1'b1;
                    w_state_next    = ST_IDLE;
                    w_wait_cnt_next = '0;
                end else begin
                    w_stall         = 1'b1;
                    w_wait_cnt_next = r_wait_cnt - c_nb_wait'(1);
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane placement and byte enables
    // ------------------------------------------------------------------
    logic [c_nb_lanes-1:0] w_be;
    logic [NB_DATA-1:0]    w_wdata;
    logic                  w_mem_we;

    always_comb begin
        w_be    = '0;
        w_wdata = '0;
        case (w_size)
            c_size_byte: begin
                w_be    = c_nb_lanes'(1) << w_lane;
                w_wdata = NB_DATA'(i_mem_data[7:0]) << {w_lane, 3'b000};
            end
            c_size_half: begin
                w_be    = c_nb_lanes'(3) << w_lane;
                w_wdata = NB_DATA'(i_mem_data[15:0]) << {w_lane, 3'b000};
            end
            default: begin
                w_be    = '1;
                w_wdata = i_mem_data;
            end
        endcase
    end

    // Gating with the reset keeps a store from landing while reset is held
    assign w_mem_we = w_commit & w_wr & ~w_misaligned & i_reset;

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [NB_DATA-1:0] w_rd_word;

    data_mem_be #(
        .NB_DATA  (NB_DATA),
        .N_WORDS  (N_WORDS),
        .NB_WADDR (c_nb_waddr)
    ) u_data_mem (
        .i_clk      (i_clk),
        .i_we       (w_mem_we),
        .i_be       (w_be),
        .i_waddr    (w_word_idx),
        .i_wdata    (w_wdata),
        .i_raddr    (w_word_idx),
        .o_rdata    (w_rd_word),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    // ------------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------------
    logic [c_max_data-1:0] w_ext_full;
    logic [NB_DATA-1:0]    w_load;

    assign w_ext_full = lane_extend(c_max_data'(w_rd_word), w_lane, w_size, w_is_unsigned);
    assign w_load     = w_ext_full[NB_DATA-1:0];

    generate
        if (NB_DATA < c_max_data) begin : g_ext_trim
            logic w_unused_ext;
            assign w_unused_ext = &{1'b0, w_ext_full[c_max_data-1:NB_DATA]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [NB_CONTROL_WB-1:0]     r_control_wb;
    logic [NB_DATA-1:0]           r_mem_r_data;
    logic [NB_DATA-1:0]           r_reg_data;
    logic [NB_ADDR_REGISTERS-1:0] r_reg_num;
    logic                         r_misaligned;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_control_wb <= '0;
            r_mem_r_data <= '0;
            r_reg_data   <= '0;
            r_reg_num    <= '0;
            r_misaligned <= 1'b0;
        end else begin
            // Stall edges and faulting accesses both deliver a WB bubble
            if (w_commit && !w_misaligned) begin
                r_control_wb <= i_control_ma_wb[NB_CONTROL_WB-1:0];
            end else begin
                r_control_wb <= '0;
            end
            r_mem_r_data <= w_load;
            r_reg_data   <= NB_DATA'(i_mem_addr);
            r_reg_num    <= i_rd_num;
            if (w_misaligned && (r_state == ST_IDLE)) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    assign o_control_wb       = r_control_wb;
    assign o_mem_r_data       = r_mem_r_data;
    assign o_reg_data         = r_reg_data;
    assign o_reg_num          = r_reg_num;
    assign o_misaligned       = r_misaligned;
    assign o_stall            = w_stall;
    assign o_ex_rd_num        = i_rd_num;
    assign o_ex_ctl_reg_write = i_control_ma_wb[c_ctl_reg_write];

endmodule
`default_nettype wire

// File: tb/tb_memory_access_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access_ws
//  Description : Directed, self-checking bench for memory_access_ws. Instance
//                a uses WAIT_STATES=2, instance b uses WAIT_STATES=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_ws;

    // Control words {rd, wr, size[1:0], unsigned, reg_write, mem_to_reg}
    localparam logic [6:0] c_nop_rw = 7'b0000010;
    localparam logic [6:0] c_sw     = 7'b0110000;
    localparam logic [6:0] c_sh     = 7'b0101000;
    localparam logic [6:0] c_sb     = 7'b0100000;
    localparam logic [6:0] c_lb     = 7'b1000011;
    localparam logic [6:0] c_lbu    = 7'b1000111;
    localparam logic [6:0] c_lh     = 7'b1001011;
    localparam logic [6:0] c_lhu    = 7'b1001111;
    localparam logic [6:0] c_lw     = 7'b1010011;
    localparam logic [6:0] c_lw11   = 7'b1011011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [6:0]  a_ctl = '0, b_ctl = '0;
    logic [31:0] a_addr = '0, a_data = '0, b_addr = '0, b_data = '0;
    logic [4:0]  a_rd = '0, b_rd = '0;
    logic [5:0]  a_dbg = '0, b_dbg = '0;

    logic [1:0]  a_wb, b_wb;
    logic [31:0] a_rdata, a_regdata, a_dbgdata, b_rdata, b_regdata, b_dbgdata;
    logic [4:0]  a_regnum, a_exrd, b_regnum, b_exrd;
    logic        a_exrw, a_stall, a_mis, b_exrw, b_stall, b_mis;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  wb;
        bit          chk_data;
        logic [31:0] rdata;
        logic [31:0] regdata;
        logic [4:0]  regnum;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    memory_access_ws #(.WAIT_STATES(2)) dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_control_ma_wb(a_ctl),
        .i_mem_addr(a_addr), .i_mem_data(a_data), .i_rd_num(a_rd),
        .i_dbg_addr(a_dbg), .o_control_wb(a_wb), .o_mem_r_data(a_rdata),
        .o_reg_data(a_regdata), .o_reg_num(a_regnum), .o_ex_rd_num(a_exrd),
        .o_ex_ctl_reg_write(a_exrw), .o_stall(a_stall),
        .o_misaligned(a_mis), .o_dbg_data(a_dbgdata)
    );

    memory_access_ws #(.WAIT_STATES(0)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_control_ma_wb(b_ctl),
        .i_mem_addr(b_addr), .i_mem_data(b_data), .i_rd_num(b_rd),
        .i_dbg_addr(b_dbg), .o_control_wb(b_wb), .o_mem_r_data(b_rdata),
        .o_reg_data(b_regdata), .o_reg_num(b_regnum), .o_ex_rd_num(b_exrd),
        .o_ex_ctl_reg_write(b_exrw), .o_stall(b_stall),
        .o_misaligned(b_mis), .o_dbg_data(b_dbgdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [6:0] ctl, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rdn);
        if (!sel) begin
            a_ctl = ctl; a_addr = addr; a_data = data; a_rd = rdn;
        end else begin
            b_ctl = ctl; b_addr = addr; b_data = data; b_rd = rdn;
        end
    endtask

    // Call just after a rising edge; returns just after the commit edge.
    task automatic run_op(input bit sel, input logic [6:0] ctl, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rdn,
                          input int exp_stalls, input logic [1:0] exp_wb,
                          input bit chk_data, input logic [31:0] exp_rdata);
        exp_t e;
        int   n;
        e.wb = exp_wb; e.chk_data = chk_data; e.rdata = exp_rdata;
        e.regdata = addr; e.regnum = rdn;
        sb.push_back(e);
        drive(sel, ctl, addr, data, rdn);
        n = 0;
        @(negedge clk);
        chk("ex_rd_num", 32'(sel ? b_exrd : a_exrd), 32'(rdn));
        chk("ex_reg_write", 32'(sel ? b_exrw : a_exrw), 32'(ctl[1]));
        while ((sel ? b_stall : a_stall) && n < 16) begin
            n++;
            if (n > 1) chk("stall_bubble", 32'(sel ? b_wb : a_wb), 32'(0));
            @(negedge clk);
        end
        chk("stall_cycles", 32'(n), 32'(exp_stalls));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("control_wb", 32'(sel ? b_wb : a_wb), 32'(e.wb));
        chk("reg_data", sel ? b_regdata : a_regdata, e.regdata);
        chk("reg_num", 32'(sel ? b_regnum : a_regnum), 32'(e.regnum));
        if (e.chk_data) chk("mem_r_data", sel ? b_rdata : a_rdata, e.rdata);
        drive(sel, 7'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic chk_dbg(input bit sel, input logic [5:0] word, input logic [31:0] exp);
        if (!sel) a_dbg = word; else b_dbg = word;
        #1;
        chk("dbg_data", sel ? b_dbgdata : a_dbgdata, exp);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb", 32'(a_wb), 32'(0));
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_regdata", a_regdata, 32'h0);
        chk("rst_regnum", 32'(a_regnum), 32'(0));
        chk("rst_stall", 32'(a_stall), 32'(0));
        chk("rst_mis", 32'(a_mis), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- instance a, WAIT_STATES=2 ----------------
        run_op(0, c_nop_rw, 32'h55, 32'h0, 5'd3, 0, 2'b10, 0, 32'h0);
        run_op(0, c_sw, 32'h10, 32'h8000_00FF, 5'd0, 2, 2'b00, 0, 32'h0);
        chk_dbg(0, 6'd4, 32'h8000_00FF);
        run_op(0, c_lb, 32'h10, 32'h0, 5'd7, 2, 2'b11, 1, 32'hFFFF_FFFF);
        run_op(0, c_lbu, 32'h13, 32'h0, 5'd8, 2, 2'b11, 1, 32'h0000_0080);
        run_op(0, c_sb, 32'h11, 32'h0000_005A, 5'd0, 2, 2'b00, 0, 32'h0);
        chk_dbg(0, 6'd4, 32'h8000_5AFF);
        run_op(0, c_lb, 32'h11, 32'h0, 5'd2, 2, 2'b11, 1, 32'h0000_005A);
        run_op(0, c_sw, 32'h10, 32'hAAAA_AAAA, 5'd0, 2, 2'b00, 0, 32'h0);
        run_op(0, c_sh, 32'h12, 32'hCDEF_1234, 5'd0, 2, 2'b00, 0, 32'h0);
        chk_dbg(0, 6'd4, 32'h1234_AAAA);
        run_op(0, c_lh, 32'h12, 32'h0, 5'd4, 2, 2'b11, 1, 32'h0000_1234);
        run_op(0, c_lh, 32'h10, 32'h0, 5'd5, 2, 2'b11, 1, 32'hFFFF_AAAA);
        run_op(0, c_lhu, 32'h10, 32'h0, 5'd6, 2, 2'b11, 1, 32'h0000_AAAA);
        chk("mis_before_fault", 32'(a_mis), 32'(0));

        // misaligned accesses: no stall, bubble, sticky flag, memory untouched
        run_op(0, c_lw, 32'h06, 32'h0, 5'd9, 0, 2'b00, 0, 32'h0);
        chk("mis_set", 32'(a_mis), 32'(1));
        run_op(0, c_sw, 32'h11, 32'hDEAD_DEAD, 5'd0, 0, 2'b00, 0, 32'h0);
        run_op(0, c_sh, 32'h13, 32'h0000_FFFF, 5'd0, 0, 2'b00, 0, 32'h0);
        chk_dbg(0, 6'd4, 32'h1234_AAAA);
        run_op(0, c_lw, 32'h10, 32'h0, 5'd9, 2, 2'b11, 1, 32'h1234_AAAA);
        chk("mis_sticky", 32'(a_mis), 32'(1));

        // ---------------- reset in the first wait cycle ----------------
        run_op(0, c_sw, 32'h20, 32'h1111_1111, 5'd0, 2, 2'b00, 0, 32'h0);
        chk_dbg(0, 6'd8, 32'h1111_1111);
        drive(0, c_sw, 32'h20, 32'hDEAD_BEEF, 5'd1);
        @(negedge clk);
        chk("abort_stall", 32'(a_stall), 32'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wb", 32'(a_wb), 32'(0));
        chk("abort_rdata", a_rdata, 32'h0);
        chk("abort_regdata", a_regdata, 32'h0);
        chk("abort_regnum", 32'(a_regnum), 32'(0));
        chk("abort_mis", 32'(a_mis), 32'(0));
        drive(0, 7'd0, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_stall_idle", 32'(a_stall), 32'(0));
        chk_dbg(0, 6'd8, 32'h1111_1111);
        @(posedge clk);
        #1;
        // size 2'b11 behaves as a word access
        run_op(0, c_lw11, 32'h10, 32'h0, 5'd10, 2, 2'b11, 1, 32'h1234_AAAA);

        // ---------------- instance b, WAIT_STATES=0 ----------------
        run_op(1, c_sw, 32'h100, 32'hCAFE_F00D, 5'd0, 0, 2'b00, 0, 32'h0);
        chk_dbg(1, 6'd0, 32'hCAFE_F00D);
        run_op(1, c_lw, 32'h000, 32'h0, 5'd11, 0, 2'b11, 1, 32'hCAFE_F00D);
        run_op(1, c_lb, 32'h101, 32'h0, 5'd12, 0, 2'b11, 1, 32'hFFFF_FFF0);
        run_op(1, c_nop_rw, 32'h1234, 32'h0, 5'd13, 0, 2'b10, 0, 32'h0);
        chk("b_mis", 32'(b_mis), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access_ws.md
# memory_access_ws

Parametrised memory-access stage for the MIPS pipeline, sitting between `execution` and write-back. It adds byte/halfword/word loads and stores with sign/zero extension and a configurable wait-state data memory. A stall handshake freezes IF/ID/EX while the access completes. It also detects misalignment, suppressing the faulting access and reporting a sticky fault, and provides a debug read port to the data memory.

## Interface
Parameters:
- `NB_DATA`, 32, data/word width (multiple of 16)
- `NB_ADDRESS`, 32, byte-address width from EX
- `N_WORDS`, 64, data-memory depth in words (power of 2)
- `NB_ADDR_REGISTERS`, 5, register-number width
- `NB_CONTROL_MA`, 5, MA control width
- `NB_CONTROL_WB`, 2, WB control width
- `WAIT_STATES`, 2, extra cycles per memory access (0..15)

Ports:
- `i_clk`  in  1  clock
- `i_reset`  in  1  asynchronous, active-low reset
- `i_control_ma_wb`  in  7  MA bits {rd, wr, size[1:0], unsigned}, then WB bits {reg_write, mem_to_reg}
- `i_mem_addr`  in  NB_ADDRESS  byte address (ALU result)
- `i_mem_data`  in  NB_DATA  store data
- `i_rd_num`  in  NB_ADDR_REGISTERS  destination register
- `i_dbg_addr`  in  log2(N_WORDS)  debug word address
- `o_control_wb`  out  NB_CONTROL_WB  registered WB control
- `o_mem_r_data`  out  NB_DATA  registered, extended load data
- `o_reg_data`  out  NB_DATA  registered pass-through ALU result
- `o_reg_num`  out  NB_ADDR_REGISTERS  registered destination
- `o_ex_rd_num`, `o_ex_ctl_reg_write`  out  5 / 1  combinational forwarding copies of inputs
- `o_stall`  out  1  combinational; pipeline must hold EX/MA inputs while high
- `o_misaligned`  out  1  sticky fault flag
- `o_dbg_data`  out  NB_DATA  combinational word read

## Operation
- Size encoding: 00 byte, 01 half, 10 word; 11 is treated as word.
- Word index is `i_mem_addr[2 +: log2(N_WORDS)]`. Higher bits are ignored, so addresses wrap modulo depth.
- Lanes are little-endian.
- Stores: SB writes lane `addr[1:0]`. SH writes lanes `{addr[1],0}`+1..0. SW writes all lanes. Unwritten lanes are preserved.
- Loads: extract the lane(s). Sign-extend unless the `unsigned` bit is set.
- Misalignment: SH/LH with `addr[0]`=1, or word access with `addr[1:0]`≠0.
  - No memory write occurs.
  - No stall occurs.
  - Output is a bubble: `o_control_wb`=0.
  - `o_misaligned` sets and stays set until reset.
- Non-memory ops (rd=wr=0) pass to the outputs in 1 cycle with no stall.
- If rd and wr are both set, the access is treated as a store.
- FSM states:
  - IDLE: an accepted aligned access with `WAIT_STATES`>0 loads a counter with `WAIT_STATES` and moves to BUSY.
  - BUSY: decrement the counter each cycle. Return to IDLE when it reaches 1.
- Memory commit happens only at the edge ending the last access cycle.

## Timing
- Access presented in cycle t. `o_stall`=1 in cycles t..t+WAIT_STATES-1 and 0 in cycle t+WAIT_STATES.
- Commit and registered outputs are updated at the end of cycle t+WAIT_STATES.
- Load-to-output latency is WAIT_STATES+1 edges. `WAIT_STATES`=0 behaves as a single-cycle stage.
- While stalled, registered outputs present a bubble each edge (`o_control_wb`=0), so no duplicate WB writes occur.
- Inputs must be stable while `o_stall`=1. The block does not re-sample them mid-access.
- Back-to-back accesses: the next access starts in the cycle after commit, with no dead cycle.
- Reset value of all registered outputs, FSM state, counter and `o_misaligned` is 0. Memory contents are not reset.
- Reset mid-access aborts the access. The pending store is never committed.
- `o_dbg_data` reflects a commit on the cycle after the commit edge.

## Structure
- Shared package `ma_pkg`:
  - size encodings
  - MA/WB bit-index constants
  - FSM state typedef (IDLE, BUSY)
  - lane-extract/extend function
- Sub-module `data_mem_be`: N_WORDS×NB_DATA array, per-byte write enables, one write port and two asynchronous read ports (access, debug).
- Top level holds the FSM, counter, alignment check, lane logic and output registers.

## Test plan
- Non-memory op (reg_write=1, ALU result 0x55, rd 3): next edge `o_reg_data`=0x55, `o_reg_num`=3, `o_stall` never high.
- WAIT_STATES=2, SW 0x8000_00FF at addr 0x10: `o_stall` high for 2 cycles; `o_dbg_data`@4 = 0x8000_00FF after commit. Then LB at 0x10 gives `o_mem_r_data`=0xFFFF_FFFF. LBU at 0x13 gives 0x0000_0080.
- SH 0x1234 at addr 0x12 over 0xAAAA_AAAA: word becomes 0x1234_AAAA. LH at 0x12 gives 0x0000_1234.
- LW at addr 0x06: no stall, `o_control_wb`=0, `o_misaligned`=1 and stays set across later valid ops. Memory is unchanged.
- Reset low in the first wait cycle of SW 0xDEAD_BEEF at 0x20: all outputs 0, word 8 unchanged.
- WAIT_STATES=0 and address 0x100 with N_WORDS=64: wraps to word 0, one-cycle latency, no stall.
